// File: rtl/random_num_pkg.sv
// Shared constants and the LFSR step function for the 2048 random number source.
// The optional reseed port set is enabled by RANDOM_NUM_LOAD_EN (see random_num_gen).
package random_num_pkg;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] TAP_MASK     = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
        logic fb;
        fb = ^(state & TAP_MASK);
        return {state[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Purely combinational single step of the 16-bit LFSR.
// Reusable wherever the next state is needed without a register.
module lfsr16_step
    import random_num_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next
);

    assign next = lfsr_next(state);

endmodule

// File: rtl/random_num_gen.sv
// Free-running 4-bit pseudo-random source built on a 16-bit maximal-length LFSR.
// Define RANDOM_NUM_LOAD_EN to add the load/seed_in reseed ports.
module random_num_gen
    import random_num_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          NUM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef RANDOM_NUM_LOAD_EN
    input  logic             load,
    input  logic [15:0]      seed_in,
`endif
    output logic [NUM_W-1:0] num
);

    // A zero seed would park the LFSR in its lock-up state, so it is replaced here.
    localparam logic [LFSR_W-1:0] EFF_SEED = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] step_next;

    lfsr16_step u_step (
        .state (lfsr_q),
        .next  (step_next)
    );

    // NOTE: assign lfsr_d unconditionally first so every path has a value and no latch is inferred.
    always_comb begin
        lfsr_d = step_next;
        if (lfsr_q == '0) begin
            lfsr_d = EFF_SEED;
        end
`ifdef RANDOM_NUM_LOAD_EN
        if (load) begin
            lfsr_d = (seed_in == '0) ? EFF_SEED : seed_in;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= EFF_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign num = lfsr_q[NUM_W-1:0];

endmodule

// File: tb/tb_random_num_gen.sv
// Scoreboard bench for random_num_gen: expected LFSR states are queued as stimulus is
// applied and popped after each rising edge. Load tests build only with RANDOM_NUM_LOAD_EN.
module tb_random_num_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num;
    logic [3:0] num0;
`ifdef RANDOM_NUM_LOAD_EN
    logic       load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [15:0] model_s;

    always #5 clk = ~clk;

    random_num_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef RANDOM_NUM_LOAD_EN
        .load    (load),
        .seed_in (seed_in),
`endif
        .num     (num)
    );

    random_num_gen #(.SEED(16'h0000)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef RANDOM_NUM_LOAD_EN
        .load    (1'b0),
        .seed_in (16'h0000),
`endif
        .num     (num0)
    );

    function automatic logic [15:0] ref_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(16'hACE1);
            tick();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (dut.lfsr_q !== exp_v || num !== exp_v[3:0]) begin
                n_err++;
                $display("FAIL reset: lfsr=%h num=%h, expected lfsr=%h num=%h", dut.lfsr_q, num, exp_v, exp_v[3:0]);
            end
            n_vec++;
            if (dut0.lfsr_q !== 16'h0001 || num0 !== 4'h1) begin
                n_err++;
                $display("FAIL seed_zero_reset: lfsr=%h num=%h, expected lfsr=0001 num=1", dut0.lfsr_q, num0);
            end
        end
        rst_n = 1'b1;
        exp_q.push_back(16'h59C3);
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v || num !== 4'h3) begin
            n_err++;
            $display("FAIL first_step: lfsr=%h num=%h, expected lfsr=%h num=3", dut.lfsr_q, num, exp_v);
        end
        n_vec++;
        if (dut0.lfsr_q !== 16'h0002 || num0 !== 4'h2) begin
            n_err++;
            $display("FAIL seed_zero_step: lfsr=%h num=%h, expected lfsr=0002 num=2", dut0.lfsr_q, num0);
        end
        exp_q.push_back(16'hB387);
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v || num !== 4'h7) begin
            n_err++;
            $display("FAIL second_step: lfsr=%h num=%h, expected lfsr=%h num=7", dut.lfsr_q, num, exp_v);
        end
        model_s = 16'hB387;
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 40; i++) begin
            model_s = ref_next(model_s);
            exp_q.push_back(model_s);
            tick();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (dut.lfsr_q !== exp_v || num !== exp_v[3:0]) begin
                n_err++;
                $display("FAIL sequence[%0d]: lfsr=%h num=%h, expected lfsr=%h num=%h", i, dut.lfsr_q, num, exp_v, exp_v[3:0]);
            end
        end
    endtask

    task automatic test_period();
        int unsigned hist[16];
        int unsigned zero_seen;
        int unsigned want;
        zero_seen = 0;
        for (int v = 0; v < 16; v++) hist[v] = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        hist[num]++;
        if (dut.lfsr_q == 16'h0000) zero_seen++;
        for (int i = 1; i < 65535; i++) begin
            tick();
            hist[num]++;
            if (dut.lfsr_q == 16'h0000) zero_seen++;
        end
        exp_q.push_back(16'hACE1);
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v) begin
            n_err++;
            $display("FAIL period_wrap: lfsr=%h, expected %h", dut.lfsr_q, exp_v);
        end
        n_vec++;
        if (zero_seen != 0) begin
            n_err++;
            $display("FAIL period_no_zero: zero states=%0d, expected 0", zero_seen);
        end
        for (int v = 0; v < 16; v++) begin
            want = (v == 0) ? 4095 : 4096;
            n_vec++;
            if (hist[v] != want) begin
                n_err++;
                $display("FAIL histogram[%0d]: count=%0d, expected %0d", v, hist[v], want);
            end
        end
    endtask

    task automatic test_midrun_reset();
        repeat (100) tick();
        rst_n = 1'b0;
        exp_q.push_back(16'hACE1);
        tick();
        rst_n = 1'b1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v || num !== 4'h1) begin
            n_err++;
            $display("FAIL midrun_reset: lfsr=%h num=%h, expected lfsr=%h num=1", dut.lfsr_q, num, exp_v);
        end
        exp_q.push_back(ref_next(16'hACE1));
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v) begin
            n_err++;
            $display("FAIL midrun_restart: lfsr=%h, expected %h", dut.lfsr_q, exp_v);
        end
    endtask

    task automatic test_zero_recovery();
        repeat (7) tick();
        force dut.lfsr_q = 16'h0000;
        #1;
        release dut.lfsr_q;
        exp_q.push_back(16'hACE1);
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v || num !== 4'h1) begin
            n_err++;
            $display("FAIL zero_recovery: lfsr=%h num=%h, expected lfsr=%h num=1", dut.lfsr_q, num, exp_v);
        end
        exp_q.push_back(16'h59C3);
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v) begin
            n_err++;
            $display("FAIL zero_recovery_resume: lfsr=%h, expected %h", dut.lfsr_q, exp_v);
        end
    endtask

`ifdef RANDOM_NUM_LOAD_EN
    task automatic test_load();
        load = 1'b1;
        seed_in = 16'h1234;
        exp_q.push_back(16'h1234);
        tick();
        load = 1'b0;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v || num !== 4'h4) begin
            n_err++;
            $display("FAIL load_value: lfsr=%h num=%h, expected lfsr=%h num=4", dut.lfsr_q, num, exp_v);
        end
        exp_q.push_back(ref_next(16'h1234));
        tick();
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v || num !== exp_v[3:0]) begin
            n_err++;
            $display("FAIL load_resume: lfsr=%h num=%h, expected lfsr=%h num=%h", dut.lfsr_q, num, exp_v, exp_v[3:0]);
        end
        load = 1'b1;
        seed_in = 16'h0000;
        exp_q.push_back(16'hACE1);
        tick();
        load = 1'b0;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v) begin
            n_err++;
            $display("FAIL load_zero_seed: lfsr=%h, expected %h", dut.lfsr_q, exp_v);
        end
        repeat (3) tick();
        load = 1'b1;
        seed_in = 16'h1234;
        rst_n = 1'b0;
        exp_q.push_back(16'hACE1);
        tick();
        load = 1'b0;
        rst_n = 1'b1;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (dut.lfsr_q !== exp_v) begin
            n_err++;
            $display("FAIL load_vs_reset: lfsr=%h, expected %h", dut.lfsr_q, exp_v);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_period();
        test_midrun_reset();
        test_zero_recovery();
`ifdef RANDOM_NUM_LOAD_EN
        test_load();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
